// File: rtl/regfile_ctx_seq_pkg.sv
// Shared definitions for the register-file context save/restore sequencer.
package regfile_ctx_seq_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam int NUM_REGS  = 32;

    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_SAVE_ENC    = 2'd1;
    localparam logic [1:0] ST_RESTORE_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_SAVE    = ST_SAVE_ENC,
        ST_RESTORE = ST_RESTORE_ENC,
        ST_DONE    = ST_DONE_ENC
    } state_t;

endpackage

// File: rtl/regfile_ctx_seq_port_mux.sv
// Regfile write-port arbiter: the pipeline drives the port unless the sequencer owns it.
module regfile_port_mux
    import regfile_ctx_seq_pkg::*;
(
    input  logic                 seq_own,
    input  logic                 block_pipe,
    input  logic                 pipe_we,
    input  logic [REG_IDX_W-1:0] pipe_wreg,
    input  logic [DATA_W-1:0]    pipe_wdata,
    input  logic                 seq_we,
    input  logic [REG_IDX_W-1:0] seq_wreg,
    input  logic [DATA_W-1:0]    seq_wdata,
    output logic                 we,
    output logic [REG_IDX_W-1:0] wreg,
    output logic [DATA_W-1:0]    wdata
);

    // Pipeline writes arriving while the sequencer is busy are dropped, never deferred.
    assign we    = seq_own ? seq_we    : (pipe_we & ~block_pipe);
    assign wreg  = seq_own ? seq_wreg  : pipe_wreg;
    assign wdata = seq_own ? seq_wdata : pipe_wdata;

endmodule

// File: rtl/regfile_ctx_seq.sv
// Context save/restore sequencer owning the regfile write port and read port C during a transfer.
module regfile_ctx_seq
    import regfile_ctx_seq_pkg::*;
#(
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 31
) (
    input  logic                 clock,
    input  logic                 ctrl_reset_n,
    input  logic                 start_save,
    input  logic                 start_restore,
    output logic                 busy,
    output logic                 done,
    output logic                 err_pipe_write,
    input  logic                 pipe_we,
    input  logic [REG_IDX_W-1:0] pipe_wreg,
    input  logic [DATA_W-1:0]    pipe_wdata,
    output logic                 ctrl_writeEnable,
    output logic [REG_IDX_W-1:0] ctrl_writeReg,
    output logic [DATA_W-1:0]    data_writeReg,
    output logic [REG_IDX_W-1:0] ctrl_readRegC,
    input  logic [DATA_W-1:0]    data_readRegC,
    output logic [DATA_W-1:0]    save_data,
    output logic                 save_valid,
    input  logic                 save_ready,
    input  logic [DATA_W-1:0]    restore_data,
    input  logic                 restore_valid,
    output logic                 restore_ready,
    output state_t               dbg_state
);

    localparam logic [REG_IDX_W-1:0] FIRST_IDX = REG_IDX_W'(FIRST_REG);
    localparam logic [REG_IDX_W-1:0] LAST_IDX  = REG_IDX_W'(LAST_REG);

    state_t               state;
    logic [REG_IDX_W-1:0] idx;
    logic                 save_fire;
    logic                 restore_fire;

    // Stream handshakes: a beat moves on a rising edge where valid and ready are both high.
    // save_valid / restore_ready are registered and high exactly while in SAVE / RESTORE.
    assign save_fire    = save_valid & save_ready;
    assign restore_fire = restore_ready & restore_valid;
    assign save_data    = data_readRegC;
    assign dbg_state    = state;

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state          <= ST_IDLE;
            idx            <= FIRST_IDX;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_pipe_write <= 1'b0;
            save_valid     <= 1'b0;
            restore_ready  <= 1'b0;
            ctrl_readRegC  <= '0;
        end else begin
            if (busy && pipe_we) begin
                err_pipe_write <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start_save) begin
                        state          <= ST_SAVE;
                        idx            <= FIRST_IDX;
                        busy           <= 1'b1;
                        save_valid     <= 1'b1;
                        ctrl_readRegC  <= FIRST_IDX;
                        err_pipe_write <= 1'b0;
                    end else if (start_restore) begin
                        state          <= ST_RESTORE;
                        idx            <= FIRST_IDX;
                        busy           <= 1'b1;
                        restore_ready  <= 1'b1;
                        err_pipe_write <= 1'b0;
                    end
                end
                ST_SAVE: begin
                    if (save_fire) begin
                        if (idx == LAST_IDX) begin
                            state         <= ST_DONE;
                            done          <= 1'b1;
                            save_valid    <= 1'b0;
                            ctrl_readRegC <= '0;
                        end else begin
                            idx           <= idx + 1'b1;
                            ctrl_readRegC <= idx + 1'b1;
                        end
                    end
                end
                ST_RESTORE: begin
                    if (restore_fire) begin
                        if (idx == LAST_IDX) begin
                            state         <= ST_DONE;
                            done          <= 1'b1;
                            restore_ready <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    regfile_port_mux u_port_mux (
        .seq_own    (restore_ready),
        .block_pipe (busy),
        .pipe_we    (pipe_we),
        .pipe_wreg  (pipe_wreg),
        .pipe_wdata (pipe_wdata),
        .seq_we     (restore_valid),
        .seq_wreg   (idx),
        .seq_wdata  (restore_data),
        .we         (ctrl_writeEnable),
        .wreg       (ctrl_writeReg),
        .wdata      (data_writeReg)
    );

endmodule

// File: tb/tb_regfile_ctx_seq.sv
// Bench for regfile_ctx_seq: a behavioural regfile plus save-stream and write-port scoreboards.
module tb_regfile_ctx_seq;
    import regfile_ctx_seq_pkg::*;

    logic        clock = 1'b0;
    logic        ctrl_reset_n = 1'b0;
    logic        start_save = 1'b0;
    logic        start_restore = 1'b0;
    logic        busy, done, err_pipe_write;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_wreg = '0;
    logic [31:0] pipe_wdata = '0;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegC;
    logic [31:0] data_readRegC;
    logic [31:0] save_data;
    logic        save_valid;
    logic        save_ready = 1'b0;
    logic [31:0] restore_data = '0;
    logic        restore_valid = 1'b0;
    logic        restore_ready;
    state_t      dbg_state;

    logic [31:0] rf [32];
    logic [31:0] exp_sv_q [$];
    logic [36:0] exp_wr_q [$];
    int          n_checks = 0;
    int          n_pass = 0;

    regfile_ctx_seq dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .start_save       (start_save),
        .start_restore    (start_restore),
        .busy             (busy),
        .done             (done),
        .err_pipe_write   (err_pipe_write),
        .pipe_we          (pipe_we),
        .pipe_wreg        (pipe_wreg),
        .pipe_wdata       (pipe_wdata),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegC    (ctrl_readRegC),
        .data_readRegC    (data_readRegC),
        .save_data        (save_data),
        .save_valid       (save_valid),
        .save_ready       (save_ready),
        .restore_data     (restore_data),
        .restore_valid    (restore_valid),
        .restore_ready    (restore_ready),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- regfile model ----------------
    assign data_readRegC = rf[ctrl_readRegC];
    always @(posedge clock) begin
        if (ctrl_writeEnable && ctrl_writeReg != 5'd0) rf[ctrl_writeReg] = data_writeReg;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_checks++;
        $display("FAIL %s: got %0h expected no transfer", name, act);
    endtask

    // ---------------- monitors ----------------
    logic [31:0] held_data;
    logic        stalled = 1'b0;
    always @(negedge clock) begin
        logic [31:0] e;
        if (!ctrl_reset_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled && save_valid) check("save_data_stable", save_data, held_data);
            if (save_valid && save_ready) begin
                if (exp_sv_q.size() == 0) unexpected("save_beat", save_data);
                else begin
                    e = exp_sv_q.pop_front();
                    check("save_beat", save_data, e);
                end
            end
            stalled   = save_valid && !save_ready;
            held_data = save_data;
        end
    end

    always @(negedge clock) begin
        logic [36:0] e;
        if (ctrl_writeEnable) begin
            if (exp_wr_q.size() == 0) unexpected("regfile_write", {ctrl_writeReg, data_writeReg});
            else begin
                e = exp_wr_q.pop_front();
                check("regfile_write", {ctrl_writeReg, data_writeReg}, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [31:0] base);
        rf[0] = '0;
        for (int i = 1; i < 32; i++) rf[i] = base + 32'(i);
    endtask

    // Wait (bounded) for the done pulse; returns the cycle count since the sampling edge.
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clock);
            if (done) begin
                cyc = c;
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int cyc;
        preload(32'h0);

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_pipe_write, 0);
        check("rst_save_valid", save_valid, 0);
        check("rst_restore_ready", restore_ready, 0);
        check("rst_readRegC", ctrl_readRegC, 0);
        check("rst_state", dbg_state, ST_IDLE);
        @(posedge clock); #1 ctrl_reset_n = 1'b1;

        // Pass-through write in IDLE
        @(posedge clock); #1;
        pipe_we = 1'b1; pipe_wreg = 5'd5; pipe_wdata = 32'hDEADBEEF;
        exp_wr_q.push_back({5'd5, 32'hDEADBEEF});
        @(negedge clock);
        check("pass_we", ctrl_writeEnable, 1);
        check("pass_wreg", ctrl_writeReg, 5);
        @(posedge clock); #1 pipe_we = 1'b0;
        check("pass_rf5", rf[5], 32'hDEADBEEF);

        // Save, ready held high
        preload(32'h100);
        for (int i = 1; i < 32; i++) exp_sv_q.push_back(32'h100 + 32'(i));
        save_ready = 1'b1;
        @(posedge clock); #1 start_save = 1'b1;
        @(posedge clock); #1 start_save = 1'b0;
        wait_done(cyc);
        check("save_done_cycle", cyc, 32);
        check("save_done_busy", busy, 1);
        @(negedge clock);
        check("save_after_busy", busy, 0);
        check("save_after_done", done, 0);
        check("save_q_drained", exp_sv_q.size(), 0);

        // Save with toggling ready, both starts together, pipe write mid-save
        for (int i = 1; i < 32; i++) exp_sv_q.push_back(32'h100 + 32'(i));
        @(posedge clock); #1 start_save = 1'b1; start_restore = 1'b1;
        @(posedge clock); #1 start_save = 1'b0; start_restore = 1'b0; save_ready = 1'b1;
        @(negedge clock);
        check("both_start_state", dbg_state, ST_SAVE);
        check("both_start_restore_ready", restore_ready, 0);
        cyc = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clock); #1;
            save_ready = ~save_ready;
            pipe_we    = (c == 6);
            pipe_wreg  = 5'd3;
            pipe_wdata = 32'h12345678;
            @(negedge clock);
            if (done) begin
                cyc = c;
                break;
            end
        end
        pipe_we = 1'b0;
        check("toggle_done_seen", cyc != 0, 1);
        check("toggle_err_set", err_pipe_write, 1);
        check("toggle_r3_kept", rf[3], 32'h103);
        check("toggle_q_drained", exp_sv_q.size(), 0);

        // Restore with valid gaps; start clears the sticky error
        for (int i = 1; i < 32; i++) exp_wr_q.push_back({5'(i), 32'hA0000000 + 32'(i)});
        @(posedge clock); #1 start_restore = 1'b1;
        @(posedge clock); #1 start_restore = 1'b0;
        @(negedge clock);
        check("restore_err_cleared", err_pipe_write, 0);
        check("restore_ready_high", restore_ready, 1);
        check("restore_save_valid_low", save_valid, 0);
        @(posedge clock); #1;
        for (int i = 1; i < 32; i++) begin
            if (i % 4 == 0) begin
                restore_valid = 1'b0; restore_data = 32'h0;
                @(posedge clock); #1;
            end
            restore_valid = 1'b1; restore_data = 32'hA0000000 + 32'(i);
            @(posedge clock); #1;
        end
        restore_valid = 1'b0; restore_data = 32'h0;
        @(negedge clock);
        check("restore_done", done, 1);
        check("restore_done_ready", restore_ready, 0);
        @(negedge clock);
        check("restore_after_busy", busy, 0);
        check("restore_q_drained", exp_wr_q.size(), 0);
        check("restore_r1", rf[1], 32'hA0000001);
        check("restore_r16", rf[16], 32'hA0000010);
        check("restore_r31", rf[31], 32'hA000001F);

        // Reset asserted after beat 10 of a restore
        preload(32'h5A000000);
        for (int i = 1; i <= 10; i++) exp_wr_q.push_back({5'(i), 32'hB0000000 + 32'(i)});
        @(posedge clock); #1 start_restore = 1'b1;
        @(posedge clock); #1 start_restore = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            restore_valid = 1'b1; restore_data = 32'hB0000000 + 32'(i);
            @(posedge clock); #1;
        end
        ctrl_reset_n = 1'b0; restore_valid = 1'b0;
        @(negedge clock);
        check("midrst_busy", busy, 0);
        check("midrst_restore_ready", restore_ready, 0);
        check("midrst_we", ctrl_writeEnable, 0);
        check("midrst_state", dbg_state, ST_IDLE);
        @(posedge clock); #1 ctrl_reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        for (int i = 1; i < 32; i++) begin
            if (i <= 10) check("midrst_rf_written", rf[i], 32'hB0000000 + 32'(i));
            else         check("midrst_rf_untouched", rf[i], 32'h5A000000 + 32'(i));
        end
        check("midrst_q_drained", exp_wr_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
